// File: rtl/tpu_pkg.sv
// Shared types and helpers for the systolic-array receive path.
// Column packing: column j of a row occupies bits [PSUM_W*j +: PSUM_W].
package tpu_pkg;

  localparam int COLS   = 6;
  localparam int PSUM_W = 16;
  localparam int ROW_W  = COLS * PSUM_W;

  typedef logic signed [PSUM_W-1:0] psum_t;
  typedef psum_t [COLS-1:0]         row_t;

  localparam psum_t PSUM_MAX = 16'sh7FFF;
  localparam psum_t PSUM_MIN = 16'sh8000;

  // Signed 16-bit add that clamps to [-32768, 32767] instead of wrapping.
  function automatic psum_t sat_add16(input psum_t a, input psum_t b);
    logic signed [PSUM_W:0] s;
    s = {a[PSUM_W-1], a} + {b[PSUM_W-1], b};
    if (s > 17'sd32767)       return PSUM_MAX;
    else if (s < -17'sd32768) return PSUM_MIN;
    else                      return psum_t'(s[PSUM_W-1:0]);
  endfunction

endpackage

// File: rtl/psum_deskew_collector_if.sv
// Aligned-row output handshake of psum_deskew_collector.
// master = row producer (the collector), slave = downstream consumer.
interface psum_deskew_collector_if #(
  parameter int W = tpu_pkg::ROW_W
) ();

  logic [W-1:0] out_row;
  logic         out_valid;
  logic         out_ready;

  modport master (output out_row, output out_valid, input out_ready);
  modport slave  (input out_row, input out_valid, output out_ready);

endinterface

// File: rtl/psum_row_fifo.sv
// Synchronous row FIFO with a registered head word.
// Full is judged before any same-cycle pop, so a push into a full FIFO is
// refused even when the head leaves in that cycle. Pointers wrap mod DEPTH.
module psum_row_fifo
  import tpu_pkg::*;
#(
  parameter int W     = ROW_W,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop_ready,
  output logic [W-1:0]             head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_ptr_nx;
  logic [CW-1:0] count_q, count_d;
  logic [W-1:0]  head_q, head_d;
  logic          empty, do_push, do_pop;

  assign full      = (count_q == CW'(DEPTH));
  assign empty     = (count_q == '0);
  assign valid     = !empty;
  assign do_push   = push && !full;
  assign do_pop    = valid && pop_ready;
  assign rd_ptr_nx = rd_ptr_q + AW'(1);
  assign head      = head_q;
  assign count     = count_q;

  // Next pointers, occupancy and head word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    count_d  = count_q;
    head_d   = head_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (do_pop) begin
      if (count_q > CW'(1)) head_d = mem_q[rd_ptr_nx];
      else if (do_push)     head_d = wdata;
    end else if (empty && do_push) begin
      head_d = wdata;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Storage array write.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; the pointers and count make stale words unreachable.
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/psum_deskew_collector.sv
// Receive end of the systolic array's south edge: realigns column-skewed
// partial sums into whole rows, queues them and hands them downstream.
// Column j lags column 0 by j cycles, so it is delayed COLS-1-j stages.
// The array cannot stall: a row arriving at a full FIFO is dropped and the
// sticky overflow flag is raised.
// Optional feature macro: PSUM_ACC_EN -- accumulate acc_len aligned rows per
// column (saturating) and queue only the group sum.
module psum_deskew_collector
  import tpu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ROW_W-1:0]       psum_in,
  input  logic                   psum_in_valid,
  psum_deskew_collector_if.master out,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   overflow,
  input  logic                   ovf_clr
`ifdef PSUM_ACC_EN
  ,
  input  logic [3:0]             acc_len
`endif
);

  localparam int NSTG = COLS - 1;

  row_t            col_in;
  row_t            al_row;
  logic [NSTG-1:0] vld_q, vld_d;
  logic            v_al;
  logic            push_req;
  row_t            push_row;
  logic            fifo_full;
  logic            drop;
  logic            ovf_q, ovf_d;

  assign col_in = psum_in;

  // ---------------------------------------------------------------- deskew
  for (genvar j = 0; j < COLS - 1; j++) begin : g_dly
    localparam int D = COLS - 1 - j;
    psum_t line_q [D];
    psum_t line_d [D];

    // Shift column j one stage per cycle toward the aligned tap.
    always_comb begin
      line_d[0] = col_in[j];
      for (int s = 1; s < D; s++) line_d[s] = line_q[s-1];
    end

    // Column j delay-line registers, cleared on reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        for (int s = 0; s < D; s++) line_q[s] <= '0;
      end else begin
        for (int s = 0; s < D; s++) line_q[s] <= line_d[s];
      end
    end

    assign al_row[j] = line_q[D-1];
  end

  // Last column arrives already aligned.
  assign al_row[COLS-1] = col_in[COLS-1];

  // Row marker follows column 0 down its own delay line.
  always_comb begin
    vld_d = {vld_q[NSTG-2:0], psum_in_valid};
  end

  // Valid delay-line register.
  always_ff @(posedge clk) begin
    if (rst) vld_q <= '0;
    else     vld_q <= vld_d;
  end

  assign v_al = vld_q[NSTG-1];

  // ---------------------------------------------------------- accumulation
`ifdef PSUM_ACC_EN
  row_t       acc_q, acc_d;
  logic [3:0] grp_cnt_q, grp_cnt_d;
  logic [3:0] grp_len_q, grp_len_d;
  logic [3:0] eff_len;
  logic       grp_first;
  row_t       sum_row;

  // Group bookkeeping: first row samples acc_len, the last row emits the sum.
  always_comb begin
    acc_d     = acc_q;
    grp_cnt_d = grp_cnt_q;
    grp_len_d = grp_len_q;
    push_req  = 1'b0;
    push_row  = al_row;
    grp_first = (grp_cnt_q == 4'd0);
    eff_len   = grp_len_q;
    if (grp_first) eff_len = (acc_len == 4'd0) ? 4'd1 : acc_len;
    for (int j = 0; j < COLS; j++) begin
      sum_row[j] = grp_first ? al_row[j] : sat_add16(acc_q[j], al_row[j]);
    end
    if (v_al) begin
      grp_len_d = eff_len;
      if (grp_cnt_q + 4'd1 == eff_len) begin
        // Group closes; accumulators restart even if the FIFO drops the sum.
        push_req  = 1'b1;
        push_row  = sum_row;
        acc_d     = '0;
        grp_cnt_d = 4'd0;
      end else begin
        acc_d     = sum_row;
        grp_cnt_d = grp_cnt_q + 4'd1;
      end
    end
  end

  // Accumulator and group-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q     <= '0;
      grp_cnt_q <= '0;
      grp_len_q <= '0;
    end else begin
      acc_q     <= acc_d;
      grp_cnt_q <= grp_cnt_d;
      grp_len_q <= grp_len_d;
    end
  end
`else
  assign push_req = v_al;
  assign push_row = al_row;
`endif

  // ------------------------------------------------------------------ FIFO
  psum_row_fifo #(
    .W     (ROW_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .wdata     (push_row),
    .pop_ready (out.out_ready),
    .head      (out.out_row),
    .valid     (out.out_valid),
    .count     (fifo_count),
    .full      (fifo_full)
  );

  // -------------------------------------------------------------- overflow
  assign drop = push_req && fifo_full;

  // Sticky drop flag; a drop in the clearing cycle keeps it set.
  always_comb begin
    ovf_d = ovf_q;
    if (drop)         ovf_d = 1'b1;
    else if (ovf_clr) ovf_d = 1'b0;
  end

  // Overflow flag register.
  always_ff @(posedge clk) begin
    if (rst) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign overflow = ovf_q;

endmodule
